// File: rtl/ckg_ctrl.sv
// rtl/ckg_ctrl.sv - per-channel clock-gate enable controller with round-robin wake scheduler
module ckg_ctrl #(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              CK,
  input  logic              RDN,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    ch_en,
  input  logic [IDLE_W-1:0] idle_thr,
  input  logic              force_on,
  output logic [NCH-1:0]    gate_en,
  output logic [NCH-1:0]    ack,
  output logic              waking
);

  localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_ON, ST_HOLD} state_t;

  state_t            state_q  [NCH];
  logic [3:0]        wake_cnt [NCH];
  logic [IDLE_W-1:0] idle_cnt [NCH];
  logic [NCH-1:0]    gate_q;
  logic [NCH-1:0]    ack_q;
  logic [RRW-1:0]    rr;

  logic [NCH-1:0]    elig;
  logic [NCH-1:0]    grant;
  logic              grant_vld;
  logic [RRW-1:0]    grant_idx;
  logic [NCH-1:0]    wake_nxt;

  // Channel index arithmetic modulo NCH, used for the rotating search and pointer update.
  function automatic logic [RRW-1:0] wrap_idx(input int v);
    return RRW'(v % NCH);
  endfunction

  // A channel may be woken only from OFF, with its request up and its mask open.
  always_comb begin
    elig = '0;
    for (int c = 0; c < NCH; c++) begin
      elig[c] = req[c] & ch_en[c] & (state_q[c] == ST_OFF);
    end
  end

  // Round-robin pick of at most one eligible channel, searching upward from rr.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_vld && elig[wrap_idx(int'(rr) + i)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_idx(int'(rr) + i);
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Which channels will sit in WAKE after this edge; feeds the registered waking flag.
  always_comb begin
    wake_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      wake_nxt[c] = ch_en[c] &
                    (((state_q[c] == ST_OFF) & grant[c]) |
                     ((state_q[c] == ST_WAKE) & (wake_cnt[c] != 4'd1)));
    end
  end

  // Per-channel FSMs, counters, scheduler pointer and registered outputs.
  always_ff @(posedge CK or negedge RDN) begin
    if (!RDN) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c]  <= ST_OFF;
        wake_cnt[c] <= '0;
        idle_cnt[c] <= '0;
      end
      gate_q <= '0;
      ack_q  <= '0;
      rr     <= '0;
      waking <= 1'b0;
    end else begin
      waking <= |wake_nxt;
      if (grant_vld) begin
        rr <= wrap_idx(int'(grant_idx) + 1);
      end
      for (int c = 0; c < NCH; c++) begin
        if (!ch_en[c]) begin
          // Mask wins over everything, including an in-flight wake.
          state_q[c]  <= ST_OFF;
          wake_cnt[c] <= '0;
          idle_cnt[c] <= '0;
          gate_q[c]   <= 1'b0;
          ack_q[c]    <= 1'b0;
        end else begin
          case (state_q[c])
            ST_OFF: begin
              if (grant[c]) begin
                state_q[c]  <= ST_WAKE;
                wake_cnt[c] <= 4'(WAKE_CYC);
                gate_q[c]   <= 1'b1;
              end
            end
            ST_WAKE: begin
              // A dropped request does not abort; the channel settles and then idles out.
              wake_cnt[c] <= wake_cnt[c] - 4'd1;
              if (wake_cnt[c] == 4'd1) begin
                state_q[c] <= ST_ON;
                ack_q[c]   <= 1'b1;
              end
            end
            ST_ON: begin
              if (!req[c]) begin
                state_q[c]  <= ST_HOLD;
                idle_cnt[c] <= '0;
              end
            end
            ST_HOLD: begin
              if (req[c]) begin
                state_q[c] <= ST_ON;
              end else if (idle_cnt[c] == idle_thr) begin
                state_q[c] <= ST_OFF;
                gate_q[c]  <= 1'b0;
                ack_q[c]   <= 1'b0;
              end else begin
                idle_cnt[c] <= idle_cnt[c] + 1'b1;
              end
            end
            default: begin
              state_q[c] <= ST_OFF;
              gate_q[c]  <= 1'b0;
              ack_q[c]   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign gate_en = gate_q | {NCH{force_on}};
  assign ack     = ack_q;

endmodule

// File: tb/tb_ckg_ctrl.sv
// tb/tb_ckg_ctrl.sv - vector-table and scoreboard bench for ckg_ctrl
module tb_ckg_ctrl;

  logic       CK;
  logic       RDN;
  logic [3:0] req;
  logic [3:0] ch_en;
  logic [7:0] idle_thr;
  logic       force_on;
  logic [3:0] gate_en;
  logic [3:0] ack;
  logic       waking;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] en;
    logic       frc;
    logic [7:0] thr;
    logic [3:0] g;
    logic [3:0] a;
    logic       w;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  ckg_ctrl #(.NCH(4), .IDLE_W(8), .WAKE_CYC(2)) dut (
    .CK       (CK),
    .RDN      (RDN),
    .req      (req),
    .ch_en    (ch_en),
    .idle_thr (idle_thr),
    .force_on (force_on),
    .gate_en  (gate_en),
    .ack      (ack),
    .waking   (waking)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] e, input logic f, input logic [7:0] t,
                     input logic [3:0] g, input logic [3:0] a, input logic w);
    vecs.push_back(vec_t'{req: r, en: e, frc: f, thr: t, g: g, a: a, w: w});
  endtask

  initial begin
    vec_t v;
    vec_t x;

    // reset release with all four requesting: grants 0,1,2,3, ack two cycles behind
    add(4'hF, 4'hF, 0, 0, 4'h1, 4'h0, 1);
    add(4'hF, 4'hF, 0, 0, 4'h3, 4'h0, 1);
    add(4'hF, 4'hF, 0, 0, 4'h7, 4'h1, 1);
    add(4'hF, 4'hF, 0, 0, 4'hF, 4'h3, 1);
    add(4'hF, 4'hF, 0, 0, 4'hF, 4'h7, 1);
    add(4'hF, 4'hF, 0, 0, 4'hF, 4'hF, 0);
    // release with idle_thr=0: exactly one HOLD cycle
    add(4'h0, 4'hF, 0, 0, 4'hF, 4'hF, 0);
    add(4'h0, 4'hF, 0, 0, 4'h0, 4'h0, 0);
    // single channel 1, idle_thr=3, req high 5 cycles then 4 HOLD cycles
    add(4'h2, 4'hF, 0, 3, 4'h2, 4'h0, 1);
    add(4'h2, 4'hF, 0, 3, 4'h2, 4'h0, 1);
    add(4'h2, 4'hF, 0, 3, 4'h2, 4'h2, 0);
    add(4'h2, 4'hF, 0, 3, 4'h2, 4'h2, 0);
    add(4'h2, 4'hF, 0, 3, 4'h2, 4'h2, 0);
    add(4'h0, 4'hF, 0, 3, 4'h2, 4'h2, 0);
    add(4'h0, 4'hF, 0, 3, 4'h2, 4'h2, 0);
    add(4'h0, 4'hF, 0, 3, 4'h2, 4'h2, 0);
    add(4'h0, 4'hF, 0, 3, 4'h2, 4'h2, 0);
    add(4'h0, 4'hF, 0, 3, 4'h0, 4'h0, 0);
    // channel 2 granted, then 3,0,1 contend: order 3,0,1
    add(4'h4, 4'hF, 0, 0, 4'h4, 4'h0, 1);
    add(4'hF, 4'hF, 0, 0, 4'hC, 4'h0, 1);
    add(4'hF, 4'hF, 0, 0, 4'hD, 4'h4, 1);
    add(4'hF, 4'hF, 0, 0, 4'hF, 4'hC, 1);
    add(4'hF, 4'hF, 0, 0, 4'hF, 4'hD, 1);
    add(4'hF, 4'hF, 0, 0, 4'hF, 4'hF, 0);
    // hold-off rescue on channel 0 with idle_thr=5
    add(4'hE, 4'hF, 0, 5, 4'hF, 4'hF, 0);
    add(4'hE, 4'hF, 0, 5, 4'hF, 4'hF, 0);
    add(4'hE, 4'hF, 0, 5, 4'hF, 4'hF, 0);
    add(4'hF, 4'hF, 0, 5, 4'hF, 4'hF, 0);
    add(4'hF, 4'hF, 0, 5, 4'hF, 4'hF, 0);
    add(4'h0, 4'hF, 0, 0, 4'hF, 4'hF, 0);
    add(4'h0, 4'hF, 0, 0, 4'h0, 4'h0, 0);
    // mask abort of channel 2 mid-wake, then a full restart
    add(4'h4, 4'hF, 0, 0, 4'h4, 4'h0, 1);
    add(4'h4, 4'hB, 0, 0, 4'h0, 4'h0, 0);
    add(4'h4, 4'hB, 0, 0, 4'h0, 4'h0, 0);
    add(4'h4, 4'hF, 0, 0, 4'h4, 4'h0, 1);
    add(4'h4, 4'hF, 0, 0, 4'h4, 4'h0, 1);
    add(4'h4, 4'hF, 0, 0, 4'h4, 4'h4, 0);
    add(4'h0, 4'hF, 0, 0, 4'h4, 4'h4, 0);
    add(4'h0, 4'hF, 0, 0, 4'h0, 4'h0, 0);
    // override with everything OFF, and override during a wake
    add(4'h0, 4'hF, 1, 0, 4'hF, 4'h0, 0);
    add(4'h0, 4'hF, 1, 0, 4'hF, 4'h0, 0);
    add(4'h0, 4'hF, 0, 0, 4'h0, 4'h0, 0);
    add(4'h1, 4'hF, 1, 0, 4'hF, 4'h0, 1);
    add(4'h1, 4'hF, 0, 0, 4'h1, 4'h0, 1);
    add(4'h1, 4'hF, 0, 0, 4'h1, 4'h1, 0);

    RDN      = 1'b0;
    req      = 4'hF;
    ch_en    = 4'hF;
    idle_thr = 8'd0;
    force_on = 1'b0;

    // outputs stay low through several edges of reset despite requests
    repeat (3) begin
      @(negedge CK);
      chk("rst_gate", -1, {4'h0, gate_en}, 8'h00);
      chk("rst_ack", -1, {4'h0, ack}, 8'h00);
      chk("rst_waking", -1, {7'h0, waking}, 8'h00);
    end

    RDN = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      v        = vecs[i];
      req      = v.req;
      ch_en    = v.en;
      force_on = v.frc;
      idle_thr = v.thr;
      sb.push_back(v);
      @(negedge CK);
      if (sb.size() == 0) begin
        chk("sb_empty", i, 8'h01, 8'h00);
      end else begin
        x = sb.pop_front();
        chk("gate_en", i, {4'h0, gate_en}, {4'h0, x.g});
        chk("ack", i, {4'h0, ack}, {4'h0, x.a});
        chk("waking", i, {7'h0, waking}, {7'h0, x.w});
      end
    end

    // asynchronous reset while channel 0 is ON drops the clock without an edge
    req = 4'h1;
    #2;
    RDN = 1'b0;
    #1;
    chk("async_rst_gate", -2, {4'h0, gate_en}, 8'h00);
    chk("async_rst_ack", -2, {4'h0, ack}, 8'h00);
    force_on = 1'b1;
    #1;
    chk("rst_force_gate", -2, {4'h0, gate_en}, 8'h0F);
    force_on = 1'b0;
    @(negedge CK);
    req = 4'h0;
    RDN = 1'b1;
    @(negedge CK);
    chk("post_rst_gate", -3, {4'h0, gate_en}, 8'h00);

    // override reaches gate_en combinationally, with no ack
    force_on = 1'b1;
    #1;
    chk("force_comb_gate", -4, {4'h0, gate_en}, 8'h0F);
    chk("force_comb_ack", -4, {4'h0, ack}, 8'h00);
    force_on = 1'b0;
    #1;
    chk("force_off_gate", -4, {4'h0, gate_en}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ckg_ctrl.md
# ckg_ctrl

Per-channel clock-gate controller that produces the enable inputs of the integrated clock-gate cells (CKICG `E` pins) for `NCH` gated clock domains. Each client raises a level request and receives an acknowledge once its gated clock is stable. Gates are released only after a programmable idle hold-off. Wake-ups are serialised, one grant per cycle, by a round-robin scheduler to limit supply di/dt.

## Interface
- `NCH`, 4: number of gated channels (1–16).
- `IDLE_W`, 8: width of the idle hold-off counter and `idle_thr`.
- `WAKE_CYC`, 2: cycles from `gate_en` rise to `ack` rise (1–15); covers the CKICG negedge latch plus the clock-tree settle.

Ports:
- `CK` in 1: free-running ungated clock; all state is on its rising edge.
- `RDN` in 1: asynchronous active-low reset.
- `req` in NCH: per-channel level request, meaning the client needs its clock.
- `ch_en` in NCH: per-channel enable mask; 0 forces the channel off.
- `idle_thr` in IDLE_W: idle hold-off threshold, shared by all channels; quasi-static.
- `force_on` in 1: test/scan override; forces every `gate_en` bit high.
- `gate_en` out NCH: to the CKICG `E` pins; registered FSM value ORed with `force_on`.
- `ack` out NCH: the clock is running and stable for that channel; registered.
- `waking` out 1: registered; high while any channel is in WAKE.

## Operation
- Each channel has a 2-bit FSM: OFF, WAKE, ON, HOLD. Each channel also has a wake counter (4 b) and an idle counter (IDLE_W b).
- OFF: `gate_en`=0, `ack`=0. A channel is eligible when `req`=1 and `ch_en`=1. If the channel is granted, the next state is WAKE and the wake counter loads `WAKE_CYC`.
- WAKE: `gate_en`=1, `ack`=0.
  - The wake counter decrements every cycle.
  - When the counter equals 1, the next state is ON.
  - `req` falling during WAKE does not abort the wake; the channel still goes to ON, then to HOLD.
- ON: `gate_en`=1, `ack`=1. If `req`=0, the next state is HOLD and the idle counter clears to 0.
- HOLD: `gate_en`=1, `ack`=1.
  - If `req`=1, the next state is ON.
  - Otherwise, if the idle counter equals `idle_thr`, the next state is OFF.
  - Otherwise the idle counter increments.
  - The clock therefore stays on for `idle_thr`+1 HOLD cycles. With `idle_thr`=0 there is exactly 1 HOLD cycle.
- `ch_en`=0 has priority over every transition. Any state goes to OFF on the next edge, and the counters clear.
- Scheduler (round-robin):
  - Each cycle, at most one eligible OFF channel is granted.
  - The search starts at the pointer `rr` (clog2(NCH) b) and proceeds in ascending index order, wrapping.
  - On a grant, `rr` becomes the granted index + 1, modulo NCH. With no grant, `rr` holds.
- `force_on` only overrides the `gate_en` outputs. The FSMs, `ack` and the scheduler run unchanged. Deasserting `force_on` returns `gate_en` to the FSM value with no extra state.
- Reset (`RDN`=0, asynchronous):
  - All FSMs go to OFF, and all counters and `rr` go to 0.
  - `gate_en`=0 (or `force_on`), `ack`=0, `waking`=0.
  - Reset in the middle of WAKE or HOLD drops the clock immediately; clients must not depend on `ack` across reset.

## Timing
- Request at edge T with the channel granted at T: `gate_en` rises at T+1 and `ack` rises at T+1+`WAKE_CYC`. Total request-to-`ack` latency is `WAKE_CYC`+1 cycles when uncontended.
- Contention: k eligible channels requesting in the same cycle get `gate_en` on k consecutive cycles, in round-robin order.
- Release: `req` falls before edge R, so HOLD starts at R+1. `gate_en` and `ack` fall together at R+2+`idle_thr`.
- A `req` re-rise while in HOLD keeps `gate_en` and `ack` high with no gap.
- `ch_en` falls before edge E: `gate_en` and `ack` are low at E+1.
- `force_on` reaches `gate_en` combinationally, so there is zero-cycle latency for that path. Every other output path is register-to-output.
- `waking` is high during exactly the cycles in which some channel is in WAKE.

## Test plan
- Reset and idle. Hold `RDN`=0 with `req`=4'hF, then release. Required: `gate_en`=0 and `ack`=0 during reset. After release, `gate_en` bits rise on 4 consecutive cycles in order 0,1,2,3, and each `ack` rises 2 cycles after its `gate_en`.
- Single-channel latency. Use `idle_thr`=3 and pulse `req[1]` high for 5 cycles starting at T. Required: `gate_en[1]` rises at T+1 and `ack[1]` at T+3. After `req[1]` falls, `gate_en[1]` and `ack[1]` stay high for 4 more HOLD cycles, then drop.
- Round-robin fairness. After channel 2 is granted, raise `req`=4'b1011 in one cycle. Required: grant order is 3, 0, 1, with no channel granted twice.
- Hold-off rescue. Use `idle_thr`=5, drop `req[0]` for 3 cycles, then raise it again. Required: `gate_en[0]` and `ack[0]` never fall, and the FSM returns to ON.
- Mask and abort. Clear `ch_en[2]` while channel 2 is in WAKE. Required: `gate_en[2]`=0 on the next cycle and `ack[2]` never rises. Re-enabling `ch_en[2]` with `req[2]`=1 restarts a full wake.
- Override. Assert `force_on` with all channels OFF. Required: `gate_en`=4'hF in the same cycle and `ack`=0. Deasserting `force_on` returns `gate_en` to 0.
